// File: rtl/dualmem_pkg.sv
// Shared constants, response payload and byte-enable helper for the
// dual-port BRAM port master.
//   ADDR_W    word address width (512 x 64-bit words)
//   DATA_W    data width (two 32-bit BRAM halves)
//   BE_W      byte-enable width
//   RSP_DEPTH response FIFO depth = maximum outstanding requests
package dualmem_pkg;

    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned RSP_DEPTH = 2;
    localparam int unsigned RSP_CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              write;
        logic              err;
    } rsp_t;

    // A 32-bit BRAM half only has one write strobe, so its enables must agree.
    function automatic logic be_half_ok(input logic [3:0] half);
        return (half == 4'h0) || (half == 4'hF);
    endfunction

endpackage

// File: rtl/dualmem_rsp_fifo.sv
// Registered response FIFO holding rsp_t entries in request order.
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data at the tail
//   push_data  response entering the FIFO
//   pop        remove the head entry
//   head       registered head entry (stable until popped)
//   valid      FIFO not empty
//   count      number of stored entries
module dualmem_rsp_fifo
    import dualmem_pkg::*;
#(
    parameter int unsigned DEPTH = RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rsp_t                       push_data,
    input  logic                       pop,
    output rsp_t                       head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rsp_t             entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = entries[rd_ptr];
    assign valid = (count != '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        push |-> ((count != CNT_W'(DEPTH)) || pop));

endmodule

// File: rtl/dualmem_port_master.sv
// Initiator for one port of the 512x64 dual-port BRAM: turns a valid/ready
// request channel into BRAM strobes, tracks the 1-cycle read latency and
// returns ordered responses through a small FIFO.
//   clk, rst        clock, asynchronous active-high reset
//   req_*           request channel (we, addr, wdata, be)
//   rsp_*           response channel (rdata, write, err)
//   mem_en/we/addr/wdata  BRAM strobes, driven in the handshake cycle
//   mem_rdata       BRAM dout, valid one cycle after a read strobe
module dualmem_port_master
    import dualmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [BE_W-1:0]   mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned OUT_W = RSP_CNT_W + 1;

    logic                 ready_en;
    logic                 inflight;
    logic                 pend_write;
    logic                 pend_err;
    logic [RSP_CNT_W-1:0] fifo_count;
    logic [OUT_W-1:0]     outstanding;
    logic                 pop;
    logic                 accept;
    logic                 legal_be;
    rsp_t                 push_rsp;
    rsp_t                 head_rsp;

    // Credit check and issue; req_ready depends only on state and rsp_ready.
    always_comb begin
        pop         = rsp_valid & rsp_ready;
        outstanding = OUT_W'(fifo_count) + OUT_W'(inflight) - OUT_W'(pop);
        req_ready   = ready_en & (outstanding < OUT_W'(RSP_DEPTH));
        accept      = req_valid & req_ready;
        legal_be    = ~req_we | (be_half_ok(req_be[3:0]) & be_half_ok(req_be[7:4]));
        mem_en      = accept & legal_be;
        mem_we      = accept ? ({BE_W{req_we}} & req_be) : '0;
        mem_addr    = accept ? req_addr : '0;
        mem_wdata   = accept ? req_wdata : '0;
    end

    // In-flight slot: the accepted request waits here for the BRAM read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en   <= 1'b0;
            inflight   <= 1'b0;
            pend_write <= 1'b0;
            pend_err   <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            inflight   <= accept;
            pend_write <= accept & req_we;
            pend_err   <= accept & ~legal_be;
        end
    end

    // Write responses carry zero data regardless of BRAM dout.
    always_comb begin
        push_rsp       = '0;
        push_rsp.rdata = pend_write ? '0 : mem_rdata;
        push_rsp.write = pend_write;
        push_rsp.err   = pend_err;
    end

    dualmem_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_rsp),
        .pop       (pop),
        .head      (head_rsp),
        .valid     (rsp_valid),
        .count     (fifo_count)
    );

    assign rsp_rdata = head_rsp.rdata;
    assign rsp_write = head_rsp.write;
    assign rsp_err   = head_rsp.err;

endmodule
